// File: rtl/axi_riscv_amo_pkg.sv
// Shared types and constants for the RISC-V AMO to AXI5 atomic issuer.
// Compile-time option: AXI_RISCV_AMO_ISSUER_ALIGN_CHECK_EN (see issuer top).
package axi_riscv_amo_pkg;

  // AXI ATOP field constants, same names and values as axi_pkg
  localparam logic [5:0] ATOP_ATOMICSWAP = 6'b110000;
  localparam logic [1:0] ATOP_ATOMICLOAD = 2'b10;
  localparam logic       ATOP_LITTLE_END = 1'b0;
  localparam logic [2:0] ATOP_ADD  = 3'b000;
  localparam logic [2:0] ATOP_CLR  = 3'b001;
  localparam logic [2:0] ATOP_EOR  = 3'b010;
  localparam logic [2:0] ATOP_SET  = 3'b011;
  localparam logic [2:0] ATOP_SMAX = 3'b100;
  localparam logic [2:0] ATOP_SMIN = 3'b101;
  localparam logic [2:0] ATOP_UMAX = 3'b110;
  localparam logic [2:0] ATOP_UMIN = 3'b111;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [3:0] {
    AMO_SWAP = 4'd0,
    AMO_ADD  = 4'd1,
    AMO_AND  = 4'd2,
    AMO_OR   = 4'd3,
    AMO_XOR  = 4'd4,
    AMO_MAX  = 4'd5,
    AMO_MIN  = 4'd6,
    AMO_MAXU = 4'd7,
    AMO_MINU = 4'd8
  } amo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } amo_state_e;

  function automatic logic [5:0] atop_load(input logic [2:0] op);
    return {ATOP_ATOMICLOAD, ATOP_LITTLE_END, op};
  endfunction

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

  // Only word and double are legal; double needs a 64-bit bus.
  function automatic logic amo_misaligned(
    input logic [2:0]  lo,
    input logic [1:0]  size,
    input int unsigned dw
  );
    logic bad_size;
    bad_size = (size < 2'd2) || ((size == 2'd3) && (dw != 64));
    if (size == 2'd3) return bad_size || (lo != 3'b000);
    return bad_size || (lo[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/axi_riscv_amo_issuer_encode.sv
// Opcode, byte-lane, strobe and read-lane mapping for the AMO issuer.
// Purely combinational; widths follow DATA_WIDTH (32 or 64).
module axi_riscv_amo_encode
  import axi_riscv_amo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OFF_W      = $clog2(DATA_WIDTH/8)
) (
  input  amo_op_e                 i_amo,
  input  logic [OFF_W-1:0]        i_off,
  input  logic [1:0]              i_size,
  input  logic [DATA_WIDTH-1:0]   i_operand,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  output logic [5:0]              o_atop,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_strb,
  output logic [DATA_WIDTH-1:0]   o_rsp_data
);

  localparam int unsigned SW = DATA_WIDTH/8;

  logic                  w_dbl;
  logic [DATA_WIDTH-1:0] w_op;
  logic [SW-1:0]         w_mask;

  assign w_dbl = (i_size == 2'd3);

  // RISC-V AMO opcode to AXI ATOP
  always_comb begin
    o_atop = ATOP_ATOMICSWAP;
    unique case (i_amo)
      AMO_SWAP: o_atop = ATOP_ATOMICSWAP;
      AMO_ADD:  o_atop = atop_load(ATOP_ADD);
      AMO_AND:  o_atop = atop_load(ATOP_CLR);
      AMO_OR:   o_atop = atop_load(ATOP_SET);
      AMO_XOR:  o_atop = atop_load(ATOP_EOR);
      AMO_MAX:  o_atop = atop_load(ATOP_SMAX);
      AMO_MIN:  o_atop = atop_load(ATOP_SMIN);
      AMO_MAXU: o_atop = atop_load(ATOP_UMAX);
      AMO_MINU: o_atop = atop_load(ATOP_UMIN);
      default:  o_atop = ATOP_ATOMICSWAP;
    endcase
  end

  // AND has no ATOP; CLR with the complement gives the same result
  assign w_op   = (i_amo == AMO_AND) ? ~i_operand : i_operand;
  assign w_mask = w_dbl ? {SW{1'b1}} : SW'(4'hF);
  assign o_strb = w_mask << i_off;

  generate
    if (DATA_WIDTH == 64) begin : g_w64
      logic [31:0] w_word;
      assign o_wdata    = w_dbl ? w_op : {2{w_op[31:0]}};
      assign w_word     = i_off[2] ? i_rdata[63:32] : i_rdata[31:0];
      assign o_rsp_data = w_dbl ? i_rdata : {{32{w_word[31]}}, w_word};
    end else begin : g_w32
      assign o_wdata    = w_op;
      assign o_rsp_data = i_rdata;
    end
  endgenerate

endmodule

// File: rtl/axi_riscv_amo_issuer.sv
// Issues one RISC-V AMO at a time as a single-beat AXI5 atomic.
// Define AXI_RISCV_AMO_ISSUER_ALIGN_CHECK_EN to reject misaligned requests.
module axi_riscv_amo_issuer
  import axi_riscv_amo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  amo_op_e                 req_amo_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [1:0]              req_size_i,
  input  logic [DATA_WIDTH-1:0]   req_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [2:0]              aw_size_o,
  output logic [5:0]              aw_atop_o,
  output logic [ID_WIDTH-1:0]     aw_id_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i
);

  localparam int unsigned OFF_W = $clog2(DATA_WIDTH/8);

  amo_state_e            r_state;
  amo_state_e            w_next;
  amo_op_e               r_amo;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_operand;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_b_done;
  logic                  r_r_done;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic                  w_req_fire;
  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_b_fire;
  logic                  w_r_fire;
  logic                  w_bad;
  logic                  w_in_send;
  logic                  w_in_wait;
  logic [DATA_WIDTH-1:0] w_rsp_data;

`ifdef AXI_RISCV_AMO_ISSUER_ALIGN_CHECK_EN
  assign w_bad = amo_misaligned(req_addr_i[2:0], req_size_i, DATA_WIDTH);
`else
  assign w_bad = 1'b0;
`endif

  assign w_in_send = (r_state == ST_SEND);
  assign w_in_wait = (r_state == ST_WAIT);

  // B and R may already be taken in SEND once AW is out
  assign req_ready_o = (r_state == ST_IDLE);
  assign aw_valid_o  = w_in_send & ~r_aw_done;
  assign w_valid_o   = w_in_send & ~r_w_done;
  assign b_ready_o   = ((w_in_send & r_aw_done) | w_in_wait) & ~r_b_done;
  assign r_ready_o   = ((w_in_send & r_aw_done) | w_in_wait) & ~r_r_done;
  assign rsp_valid_o = (r_state == ST_RESP);

  assign w_req_fire = req_valid_i & req_ready_o;
  assign w_aw_fire  = aw_valid_o & aw_ready_i;
  assign w_w_fire   = w_valid_o & w_ready_i;
  assign w_b_fire   = b_valid_i & b_ready_o;
  assign w_r_fire   = r_valid_i & r_ready_o;

  assign aw_addr_o  = r_addr;
  assign aw_size_o  = {1'b0, r_size};
  assign aw_id_o    = ID_WIDTH'(AXI_ID);
  assign w_last_o   = 1'b1;
  assign rsp_data_o = r_rsp_data;
  assign rsp_err_o  = r_rsp_err;

  axi_riscv_amo_encode #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_W      (OFF_W)
  ) u_encode (
    .i_amo      (r_amo),
    .i_off      (r_addr[OFF_W-1:0]),
    .i_size     (r_size),
    .i_operand  (r_operand),
    .i_rdata    (r_data_i),
    .o_atop     (aw_atop_o),
    .o_wdata    (w_data_o),
    .o_strb     (w_strb_o),
    .o_rsp_data (w_rsp_data)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (req_valid_i) w_next = w_bad ? ST_RESP : ST_SEND;
      ST_SEND: if ((r_aw_done | w_aw_fire) & (r_w_done | w_w_fire))
                 w_next = ST_WAIT;
      ST_WAIT: if ((r_b_done | w_b_fire) & (r_r_done | w_r_fire))
                 w_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, channel completion flags and response collection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_amo      <= AMO_SWAP;
      r_addr     <= '0;
      r_size     <= '0;
      r_operand  <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_b_done   <= 1'b0;
      r_r_done   <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_req_fire) begin
        r_amo     <= req_amo_i;
        r_addr    <= req_addr_i;
        r_size    <= req_size_i;
        r_operand <= req_data_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_b_done  <= 1'b0;
        r_r_done  <= 1'b0;
        r_rsp_err <= w_bad;
      end
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire)  r_w_done  <= 1'b1;
      if (w_b_fire) begin
        r_b_done <= 1'b1;
        if (resp_is_err(b_resp_i)) r_rsp_err <= 1'b1;
      end
      if (w_r_fire) begin
        r_r_done   <= 1'b1;
        r_rsp_data <= w_rsp_data;
        if (resp_is_err(r_resp_i)) r_rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_riscv_amo_issuer.sv
// Randomized self-checking bench for axi_riscv_amo_issuer (64-bit bus).
// Honours AXI_RISCV_AMO_ISSUER_ALIGN_CHECK_EN when defined.
module tb_axi_riscv_amo_issuer;
  import axi_riscv_amo_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int AID = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  amo_op_e       req_amo_i = AMO_SWAP;
  logic [AW-1:0] req_addr_i = '0;
  logic [1:0]    req_size_i = 2'd2;
  logic [DW-1:0] req_data_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic          aw_valid_o;
  logic          aw_ready_i = 1'b0;
  logic [AW-1:0] aw_addr_o;
  logic [2:0]    aw_size_o;
  logic [5:0]    aw_atop_o;
  logic [IW-1:0] aw_id_o;
  logic          w_valid_o;
  logic          w_ready_i = 1'b0;
  logic [DW-1:0] w_data_o;
  logic [7:0]    w_strb_o;
  logic          w_last_o;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [1:0]    b_resp_i = 2'b00;
  logic          r_valid_i = 1'b0;
  logic          r_ready_o;
  logic [DW-1:0] r_data_i = '0;
  logic [1:0]    r_resp_i = 2'b00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_riscv_amo_issuer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .AXI_ID     (AID)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_amo_i   (req_amo_i),
    .req_addr_i  (req_addr_i),
    .req_size_i  (req_size_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .aw_valid_o  (aw_valid_o),
    .aw_ready_i  (aw_ready_i),
    .aw_addr_o   (aw_addr_o),
    .aw_size_o   (aw_size_o),
    .aw_atop_o   (aw_atop_o),
    .aw_id_o     (aw_id_o),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .w_data_o    (w_data_o),
    .w_strb_o    (w_strb_o),
    .w_last_o    (w_last_o),
    .b_valid_i   (b_valid_i),
    .b_ready_o   (b_ready_o),
    .b_resp_i    (b_resp_i),
    .r_valid_i   (r_valid_i),
    .r_ready_o   (r_ready_o),
    .r_data_i    (r_data_i),
    .r_resp_i    (r_resp_i)
  );

  // ATOP per opcode index SWAP,ADD,AND,OR,XOR,MAX,MIN,MAXU,MINU
  logic [5:0] atop_tbl [9] = '{
    6'b110000, 6'b100000, 6'b100001, 6'b100011, 6'b100010,
    6'b100100, 6'b100101, 6'b100110, 6'b100111
  };

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0;
    aw_ready_i  = 1'b0;
    w_ready_i   = 1'b0;
    b_valid_i   = 1'b0;
    r_valid_i   = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  task automatic run_txn(
    input int          op,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic [63:0] opd,
    input logic [63:0] rdata,
    input logic [1:0]  bresp,
    input logic [1:0]  rresp,
    input int          aw_dly,
    input int          w_dly,
    input int          b_dly,
    input int          r_dly,
    input int          rsp_dly
  );
    int          off, nb, t, rsp_t0, aw_n;
    logic [63:0] e_wdata, e_rsp, tmp;
    logic [31:0] word;
    logic [7:0]  e_strb;
    logic        e_err, bad;
    logic        aw_d, w_d, b_d, r_d, rsp_d, aw_seen, w_seen;
    logic        rec_aw, rec_w, rec_b, rec_r, rec_rsp;
    off = int'(addr % 8);
    nb  = 1 << size;
    bad = 1'b0;
`ifdef AXI_RISCV_AMO_ISSUER_ALIGN_CHECK_EN
    bad = (addr % nb) != 0;
`endif
    e_strb  = 8'(((1 << nb) - 1) << off);
    tmp     = (op == 2) ? ~opd : opd;
    e_wdata = (size == 2'd3) ? tmp : {tmp[31:0], tmp[31:0]};
    word    = 32'(rdata >> (8 * ((off / 4) * 4)));
    e_rsp   = (size == 2'd3) ? rdata : 64'($signed(word));
    e_err   = bad || (bresp >= 2) || (rresp >= 2);

    @(negedge clk);
    chk("req_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_amo_i   = amo_op_e'(op[3:0]);
    req_addr_i  = addr;
    req_size_i  = size;
    req_data_i  = opd;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_data_i  = {$urandom, $urandom};
    {aw_d, w_d, b_d, r_d, rsp_d, aw_seen, w_seen} = '0;
    {rec_aw, rec_w, rec_b, rec_r, rec_rsp} = '0;
    t = 0; rsp_t0 = -1; aw_n = 0;
    while (t < 200) begin
      if (rec_aw) begin aw_d = 1'b1; aw_n++; end
      if (rec_w)   w_d   = 1'b1;
      if (rec_b)   b_d   = 1'b1;
      if (rec_r)   r_d   = 1'b1;
      if (rec_rsp) rsp_d = 1'b1;
      if (rsp_d) break;
      if (aw_valid_o && !aw_seen) begin
        aw_seen = 1'b1;
        chk("aw_atop", aw_atop_o, atop_tbl[op]);
        chk("aw_addr", aw_addr_o, addr);
        chk("aw_size", aw_size_o, size);
        chk("aw_id", aw_id_o, AID);
      end
      if (w_valid_o && !w_seen) begin
        w_seen = 1'b1;
        chk("w_data", w_data_o, e_wdata);
        chk("w_strb", w_strb_o, e_strb);
        chk("w_last", w_last_o, 1);
      end
      if (rsp_valid_o) begin
        if (rsp_t0 < 0) begin
          rsp_t0 = t;
          if (bad) chk("lat_max", (t + 1) <= 2, 1);
          else     chk("lat_min", (t + 1) >= 3, 1);
        end
        chk("rsp_err", rsp_err_o, e_err);
        if (!e_err) chk("rsp_data", rsp_data_o, e_rsp);
      end
      aw_ready_i  = (t >= aw_dly);
      w_ready_i   = (t >= w_dly);
      b_valid_i   = aw_d && w_d && !b_d && (t >= b_dly);
      b_resp_i    = bresp;
      r_valid_i   = aw_d && !r_d && (t >= r_dly);
      r_data_i    = rdata;
      r_resp_i    = rresp;
      rsp_ready_i = rsp_valid_o && (t - rsp_t0 >= rsp_dly);
      rec_aw  = aw_valid_o && aw_ready_i;
      rec_w   = w_valid_o && w_ready_i;
      rec_b   = b_valid_i && b_ready_o;
      rec_r   = r_valid_i && r_ready_o;
      rec_rsp = rsp_valid_o && rsp_ready_i;
      @(negedge clk);
      t++;
    end
    idle_inputs();
    chk("rsp_done", rsp_d, 1);
    chk("aw_count", aw_n, bad ? 0 : 1);
    chk("rsp_single", rsp_valid_o, 0);
  endtask

  task automatic reset_in_wait();
    int n_rsp;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_amo_i   = AMO_ADD;
    req_addr_i  = 32'h4000;
    req_size_i  = 2'd3;
    req_data_i  = 64'h1;
    aw_ready_i  = 1'b1;
    w_ready_i   = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("wait_b_ready", b_ready_o, 1);
    chk("wait_r_ready", r_ready_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid_o || aw_valid_o || w_valid_o) n_rsp++;
    end
    chk("rst_no_rsp", n_rsp, 0);
    chk("rst_idle", req_ready_o, 1);
  endtask

  initial begin
    int op, nb;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [1:0]  br, rr;
    idle_inputs();
    #1;
    chk("reset_req_ready", req_ready_o, 1);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_aw_valid", aw_valid_o, 0);
    chk("reset_w_valid", w_valid_o, 0);
    chk("reset_b_ready", b_ready_o, 0);
    chk("reset_r_ready", r_ready_o, 0);
    chk("reset_rsp_data", rsp_data_o, 0);
    chk("reset_rsp_err", rsp_err_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_txn(1, 32'h1004, 2'd2, 64'h5, 64'h80000000_12345678,
            2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn(2, 32'h2000, 2'd3, 64'hFF, 64'h0123456789ABCDEF,
            2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn(0, 32'h3008, 2'd3, 64'hCAFE, 64'hDEADBEEF00C0FFEE,
            2'b00, 2'b00, 4, 1, 8, 0, 1);
    run_txn(3, 32'h5010, 2'd3, 64'h77, 64'h55,
            2'b10, 2'b00, 0, 0, 0, 0, 5);
    run_txn(0, 32'h1002, 2'd2, 64'h1234, 64'hAAAAAAAA_7FFF0001,
            2'b00, 2'b00, 0, 0, 1, 2, 0);
    reset_in_wait();

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 8);
      sz = 2'($urandom_range(2, 3));
      nb = 1 << sz;
      a  = $urandom & ~32'(nb - 1);
      br = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      run_txn(op, a, sz, {$urandom, $urandom}, {$urandom, $urandom},
              br, rr, $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_riscv_amo_issuer.md
AXI_RISCV_AMO_ISSUER -- requirements
Module: axi_riscv_amo_issuer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width; only 32 and 64 are legal.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have parameter AXI_ID, default 0, the constant ID driven on aw_id.
REQ-005 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, reset; asynchronous, active-low).
REQ-006 SHALL have core request ports:
- req_valid_i (in, 1)
- req_ready_o (out, 1)
- req_amo_i (in, 4, amo_op_e)
- req_addr_i (in, ADDR_WIDTH)
- req_size_i (in, 2; 2=word, 3=double)
- req_data_i (in, DATA_WIDTH, operand right-aligned)
REQ-007 SHALL have core response ports:
- rsp_valid_o (out, 1)
- rsp_ready_i (in, 1)
- rsp_data_o (out, DATA_WIDTH, old memory value)
- rsp_err_o (out, 1)
REQ-008 SHALL have AXI AW ports aw_valid_o, aw_ready_i, aw_addr_o (ADDR_WIDTH), aw_size_o (3), aw_atop_o (6) and aw_id_o (ID_WIDTH); aw_len is always 0 and aw_burst is always INCR.
REQ-009 SHALL have AXI W ports w_valid_o, w_ready_i, w_data_o (DATA_WIDTH), w_strb_o (DATA_WIDTH/8) and w_last_o (constant 1).
REQ-010 SHALL have AXI B ports b_valid_i, b_ready_o and b_resp_i (2), and AXI R ports r_valid_i, r_ready_o, r_data_i (DATA_WIDTH) and r_resp_i (2).

Function
REQ-011 SHALL map req_amo_i to aw_atop_o as follows:
- SWAP -> 110000
- ADD -> 100000
- AND -> 100001 (CLR), with W data bitwise inverted
- OR -> 100011
- XOR -> 100010
- MAX -> 100100
- MIN -> 100101
- MAXU -> 100110
- MINU -> 100111
REQ-012 SHALL place the operand in byte lane addr[log2(DATA_WIDTH/8)-1:0]: replicated across both word halves for a word on a 64-bit bus, strobe covering only the addressed 2^size bytes.
REQ-013 SHALL implement FSM IDLE -> SEND -> WAIT -> RESP -> IDLE.
REQ-014 SHALL assert req_ready_o only in IDLE; a request handshake registers all request fields and enters SEND.
REQ-015 In SEND, SHALL hold aw_valid_o and w_valid_o independently until each channel handshakes, in either order or the same cycle, and enter WAIT once both have completed.
REQ-016 In WAIT, SHALL hold b_ready_o and r_ready_o high until the respective beat is accepted; B and R may arrive in any order or the same cycle, and also during SEND after AW has fired.
REQ-017 SHALL enter RESP on the cycle after both B and R have been accepted, and SHALL hold rsp_valid_o with stable data until rsp_ready_i is seen, then return to IDLE.
REQ-018 SHALL extract rsp_data_o from the addressed lane of r_data_i; word results SHALL be sign-extended to DATA_WIDTH.
REQ-019 SHALL set rsp_err_o to 1 when b_resp_i or r_resp_i is SLVERR or DECERR; rsp_data_o is then don't-care.
REQ-020 SHALL impose a minimum latency of 3 cycles from request handshake to rsp_valid_o, given zero-wait AXI.
REQ-021 SHALL have at most one outstanding AMO.

Reset
REQ-022 On rst_ni low, SHALL return the FSM to IDLE, clear all valid/ready outputs except req_ready_o (which is 1), and zero rsp_data_o and rsp_err_o.
REQ-023 SHALL abandon a transaction in flight when reset is asserted mid-operation, with no response to the core.

Configuration
REQ-024 With AXI_RISCV_AMO_ISSUER_ALIGN_CHECK_EN defined, a misaligned request (addr not a multiple of 2^size) or an illegal size SHALL skip SEND/WAIT and enter RESP directly with rsp_err_o=1 and no AXI traffic.
REQ-025 Without AXI_RISCV_AMO_ISSUER_ALIGN_CHECK_EN, addresses SHALL be issued unchecked.

Structure
REQ-026 SHALL take amo_op_e, the ATOP codes and the state enum from package axi_riscv_amo_pkg; ATOP codes reuse axi_pkg constants.
REQ-027 SHALL isolate the opcode/lane/strobe mapping in combinational sub-module axi_riscv_amo_encode.

Verification
REQ-028 SHALL cover: DATA_WIDTH=64, ADD, addr 0x1004, size 2, data 0x5, R lane4 = 0x80000000 -> aw_atop 100000, w_strb 0xF0, rsp_data 0xFFFFFFFF80000000, err 0.
REQ-029 SHALL cover: AND, size 3, data 0x00FF -> aw_atop 100001, w_data 0xFFFFFFFFFFFFFF00, w_strb 0xFF.
REQ-030 SHALL cover: W accepted 3 cycles before AW, and R returned before B -> exactly one response with correct data.
REQ-031 SHALL cover: b_resp=SLVERR with r_resp=OKAY -> rsp_err 1; rsp_ready_i held low 5 cycles -> rsp_valid and data stable throughout.
REQ-032 SHALL cover: with the macro defined, SWAP at addr 0x1002 size 2 -> no aw_valid, rsp_err 1 within 2 cycles.
REQ-033 SHALL cover: reset asserted in WAIT -> IDLE, req_ready_o 1, no rsp_valid.
